button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
// - Collects one-cycle press ticks from N push-detect front ends, arbitrates them round-robin and
//   queues them in a small event FIFO for the menu/control FSM.
// - Output is a valid/ready stream. It sits between the per-button push-detect chains and the
//   consumer logic, all in the main clk domain.
// PARAMETERS
// - N_BTN       4   number of buttons (2..16)
// - DEPTH       4   event FIFO entries (power of 2, >=2)
// - HOLD_CYC    50_000_000  cycles held before first auto-repeat (BTN_AUTOREPEAT_EN only)
// - REPEAT_CYC  10_000_000  cycles between subsequent repeats (BTN_AUTOREPEAT_EN only)
// PORTS
// - clk         in   1          system clock
// - rst         in   1          asynchronous, active-high reset
// - btn_tick    in   N_BTN      one-cycle press pulses from push detectors
// - btn_level   in   N_BTN      debounced, synchronized button levels (used by auto-repeat)
// - evt_ready   in   1          consumer accepts event
// - evt_valid   out  1          FIFO non-empty
// - evt_id      out  $clog2(N_BTN)  button index of head event
// - evt_rep     out  1          head event is an auto-repeat (0 when macro off)
// - evt_count   out  $clog2(DEPTH)+1  FIFO occupancy
// - drop_flag   out  1          sticky: a tick was lost; cleared only by rst
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset values: pending=0, rr_ptr=0, FIFO empty, evt_valid=0, evt_id=0, evt_rep=0,
//   evt_count=0, drop_flag=0. Reset mid-operation discards all queued and pending events.
// - pending[i] is set by btn_tick[i] and cleared when button i is granted.
//   - Tick and grant for the same i in the same cycle: pending[i] stays 1 (new press kept).
//   - Tick while pending[i] is already 1 and not granted that cycle: tick is lost and drop_flag=1.
// - Grant: each cycle with FIFO not full (or full with a pop that same cycle), the first pending
//   index found scanning rr_ptr, rr_ptr+1, ... wrapping mod N_BTN is pushed.
//   - After a grant, rr_ptr = granted+1 (wraps to 0).
//   - At most one push per cycle.
// - Latency: tick in cycle t -> pending in t+1 -> pushed at the end of t+1 -> evt_valid in t+2
//   (best case, FIFO empty, no contention).
// - FIFO: first-word fall-through. Pop when evt_valid&evt_ready.
//   - Simultaneous push and pop when full is allowed; count is unchanged.
//   - Pop when empty is ignored. Pointers wrap mod DEPTH.
// - evt_id, evt_rep are stable while evt_valid=1 and evt_ready=0.
// CONFIGURATION
// - BTN_AUTOREPEAT_EN defined: one shared hold timer.
//   - Timer resets to 0 whenever btn_level==0 or any btn_tick.
//   - Otherwise it counts up. On reaching HOLD_CYC-1, then every REPEAT_CYC cycles, it sets
//     pending for every button with btn_level=1 and marks those entries rep=1.
//   - Repeat requests obey the same drop rule.
// - BTN_AUTOREPEAT_EN undefined: no timer. btn_level is unused. evt_rep is tied 0. FIFO width
//   excludes the rep bit.
// STRUCTURE
// - Shared package btn_pkg: ID_W function/constant ($clog2 of N_BTN), event entry layout
//   {rep, id}, default HOLD/REPEAT cycle constants.
// - One sub-module: btn_evt_fifo (parameterized width/depth FWFT FIFO with count). Arbiter,
//   pending register and repeat timer stay in the top.
// TESTING
// - Reset then idle: all outputs 0. Assert rst mid-queue with 3 events -> evt_valid=0,
//   evt_count=0 next cycle.
// - Single tick btn_tick=4'b0100, evt_ready=0 -> evt_valid=1 at t+2, evt_id=2, evt_count=1.
// - Simultaneous btn_tick=4'b1011, rr_ptr=0, evt_ready=1 -> ids 0,1,3 on consecutive cycles.
//   Next tick 4'b0001 is granted only after 1..3 are served (fairness).
// - FIFO full (DEPTH=4, evt_ready=0), tick btn 1 twice -> first waits pending, second sets
//   drop_flag=1. Then pop one -> btn 1 pushed the same cycle, count stays 4.
// - Tick on btn 0 in the same cycle pending[0] is granted -> two id=0 events queued,
//   drop_flag=0.
// - BTN_AUTOREPEAT_EN, HOLD_CYC=20, REPEAT_CYC=8: hold btn_level[3] for 40 cycles -> repeat
//   events id=3, rep=1 at hold 20, 28, 36. Without the macro -> none.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared widths, event entry layout and default repeat timing
package btn_pkg;

    localparam int unsigned HOLD_CYC_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CYC_DEF = 10_000_000;

    function automatic int unsigned id_w(input int unsigned n_btn);
        return (n_btn < 2) ? 1 : $clog2(n_btn);
    endfunction

    // Event entry is {rep, id}; the rep bit exists only with auto-repeat built in
    function automatic int unsigned evt_w(input int unsigned n_btn, input bit with_rep);
        return id_w(n_btn) + (with_rep ? 1 : 0);
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - first-word fall-through event FIFO with occupancy count
module btn_evt_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin press arbiter feeding an event FIFO
// Optional shared hold/auto-repeat timer enabled by BTN_AUTOREPEAT_EN.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
    parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           btn_tick,
    input  logic [N_BTN-1:0]           btn_level,
    input  logic                       evt_ready,
    output logic                       evt_valid,
    output logic [$clog2(N_BTN)-1:0]   evt_id,
    output logic                       evt_rep,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       drop_flag
);
    localparam int unsigned ID_W = id_w(N_BTN);
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned EW = evt_w(N_BTN, 1'b1);
`else
    localparam int unsigned EW = evt_w(N_BTN, 1'b0);
`endif

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             drop_q, drop_d;
    logic [N_BTN-1:0] rep_req;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic             push, pop, fifo_empty, fifo_full;
    logic [EW-1:0]    fifo_din, fifo_dout;

    assign pop  = evt_valid && evt_ready;
    assign push = gnt_found && (!fifo_full || pop);

    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < int'(N_BTN); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(N_BTN);
            if (!gnt_found && pending_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (gnt_idx == ID_W'(N_BTN-1)) ? '0 : gnt_idx + 1'b1;
    end

    // A request landing on a still-pending, ungranted button is lost
    always_comb begin
        logic granted, req;
        pending_d = pending_q;
        drop_d    = drop_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            granted = push && (gnt_idx == ID_W'(i));
            req     = btn_tick[i] | rep_req[i];
            if (granted || !pending_q[i]) pending_d[i] = req;
            else if (req)                 drop_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            drop_q    <= drop_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [31:0]      timer_q, timer_d;
    logic             phase_q, phase_d;
    logic [N_BTN-1:0] rep_pend_q, rep_pend_d;

    // phase_q marks that the first repeat has fired and the shorter period applies
    always_comb begin
        timer_d = timer_q + 32'd1;
        phase_d = phase_q;
        rep_req = '0;
        if (btn_level == '0 || |btn_tick) begin
            timer_d = '0;
            phase_d = 1'b0;
        end else if (timer_q == (phase_q ? 32'(REPEAT_CYC - 1) : 32'(HOLD_CYC - 1))) begin
            timer_d = '0;
            phase_d = 1'b1;
            rep_req = btn_level;
        end
    end

    always_comb begin
        rep_pend_d = rep_pend_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if ((push && gnt_idx == ID_W'(i)) || !pending_q[i])
                rep_pend_d[i] = !btn_tick[i] && rep_req[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            phase_q    <= 1'b0;
            rep_pend_q <= '0;
        end else begin
            timer_q    <= timer_d;
            phase_q    <= phase_d;
            rep_pend_q <= rep_pend_d;
        end
    end

    assign fifo_din = {rep_pend_q[gnt_idx], gnt_idx};
    assign evt_rep  = evt_valid && fifo_dout[EW-1];
`else
    logic unused_level;
    assign unused_level = ^btn_level;
    assign rep_req      = '0;
    assign fifo_din     = gnt_idx;
    assign evt_rep      = 1'b0;
`endif

    btn_evt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (evt_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_id    = evt_valid ? fifo_dout[ID_W-1:0] : '0;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_tick = '0;
    logic [3:0] btn_level = '0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_rep;
    logic [2:0] evt_count;
    logic       drop_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int nev;
    int first_k;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN      (4),
        .DEPTH      (4),
        .HOLD_CYC   (20),
        .REPEAT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_tick  (btn_tick),
        .btn_level (btn_level),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_rep   (evt_rep),
        .evt_count (evt_count),
        .drop_flag (drop_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_tick  = '0;
        btn_level = '0;
        evt_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // reset and idle
        do_reset();
        step();
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_rep", evt_rep, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_drop", drop_flag, 0);

        // single tick, latency t+2
        btn_tick = 4'b0100;
        step();
        btn_tick = '0;
        chk("single_valid_t1", evt_valid, 0);
        step();
        chk("single_valid_t2", evt_valid, 1);
        chk("single_id", evt_id, 2);
        chk("single_count", evt_count, 1);
        step();
        chk("single_hold_id", evt_id, 2);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("single_pop_valid", evt_valid, 0);
        chk("single_pop_count", evt_count, 0);

        // round-robin 1011 with a retick of btn 0 while it is granted
        do_reset();
        evt_ready = 1'b1;
        btn_tick  = 4'b1011;
        step();
        btn_tick  = 4'b0001;
        step();
        btn_tick  = '0;
        chk("rr_id0", evt_id, 0);
        chk("rr_count", evt_count, 1);
        step();
        chk("rr_id1", evt_id, 1);
        step();
        chk("rr_id3", evt_id, 3);
        step();
        chk("rr_fair_id0", evt_id, 0);
        chk("rr_fair_valid", evt_valid, 1);
        step();
        chk("rr_empty", evt_valid, 0);
        chk("rr_drop", drop_flag, 0);
        evt_ready = 1'b0;

        // full FIFO, wait then drop, push on pop
        do_reset();
        btn_tick = 4'b1111;
        step();
        btn_tick = '0;
        repeat (4) step();
        chk("full_count", evt_count, 4);
        btn_tick = 4'b0010;
        step();
        chk("full_wait_drop", drop_flag, 0);
        chk("full_wait_count", evt_count, 4);
        step();
        btn_tick = '0;
        chk("full_drop", drop_flag, 1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("full_pushpop_count", evt_count, 4);
        chk("full_pushpop_head", evt_id, 1);
        evt_ready = 1'b1;
        step();
        chk("full_drain_id2", evt_id, 2);
        step();
        chk("full_drain_id3", evt_id, 3);
        step();
        chk("full_drain_late1", evt_id, 1);
        step();
        chk("full_drain_empty", evt_valid, 0);
        chk("full_drop_sticky", drop_flag, 1);
        evt_ready = 1'b0;

        // tick on btn 0 in its grant cycle -> two events
        do_reset();
        btn_tick = 4'b0001;
        step();
        step();
        btn_tick = '0;
        step();
        chk("same_count", evt_count, 2);
        chk("same_id", evt_id, 0);
        chk("same_drop", drop_flag, 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("same_second_id", evt_id, 0);
        chk("same_second_count", evt_count, 1);

        // reset mid-queue
        do_reset();
        btn_tick = 4'b0111;
        step();
        btn_tick = '0;
        repeat (3) step();
        chk("mid_count", evt_count, 3);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_count", evt_count, 0);
        rst = 1'b0;
        repeat (3) step();
        chk("mid_after_valid", evt_valid, 0);
        chk("mid_after_count", evt_count, 0);

        // held level on btn 3
        do_reset();
        evt_ready = 1'b1;
        btn_level = 4'b1000;
        nev = 0;
        first_k = 0;
        for (int k = 1; k <= 44; k++) begin
            step();
            if (k == 40) btn_level = '0;
            if (evt_valid) begin
                nev++;
                if (nev == 1) first_k = k;
                chk("rep_id", evt_id, 3);
`ifdef BTN_AUTOREPEAT_EN
                chk("rep_flag", evt_rep, 1);
`endif
            end
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("rep_events", nev, 3);
        chk("rep_first_cycle", first_k, 21);
`else
        chk("rep_events_none", nev, 0);
        chk("rep_tied_zero", evt_rep, 0);
`endif
        chk("rep_drop", drop_flag, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
